// File: rtl/seq1010_gen_pkg.sv
// Shared types and constants for the seq1010_gen serial pattern transmitter.
// Build option: SEQ1010_GEN_PREAMBLE_EN adds the PRE state and the 1010 preamble.
package seq1010_gen_pkg;

    localparam int PRE_LEN = 4;

`ifdef SEQ1010_GEN_PREAMBLE_EN
    localparam logic [PRE_LEN-1:0] PREAMBLE = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_GAP
    } state_t;

    // Preamble bit for position idx, sent MSB first.
    function automatic logic pre_bit(input logic [1:0] idx);
        logic [1:0] pos;
        pos = 2'd3 - idx;
        return PREAMBLE[pos];
    endfunction
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_GAP
    } state_t;
`endif

endpackage

// File: rtl/seq1010_piso.sv
// Parallel-in serial-out shift register, shifts left, MSB is the serial output.
// Ports: clk, reset (sync, active high), load, shift, d[WIDTH], sout.
module seq1010_piso
    import seq1010_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    // load together with shift means d[MSB] leaves this same edge,
    // so the register keeps only the bits still to be sent.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= shift ? (d << 1) : d;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign sout = q[WIDTH-1];

endmodule

// File: rtl/seq1010_gen.sv
// Serial pattern transmitter: sends a latched word MSB first, repeat_n+1 times.
// Ports: clk, reset, start, data_in, repeat_n -> ready, b, b_valid, done.
// Build option: SEQ1010_GEN_PREAMBLE_EN prefixes every frame with 1010.
module seq1010_gen
    import seq1010_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       repeat_n,
    output logic             ready,
    output logic             b,
    output logic             b_valid,
    output logic             done
);

    localparam int CNT_MAX = (WIDTH > PRE_LEN) ? WIDTH : PRE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int GAP_W   = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
`ifdef SEQ1010_GEN_PREAMBLE_EN
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [3:0]       rep_cnt, rep_n;
    logic [3:0]       rep_lim, rep_lim_n;
    logic [WIDTH-1:0] word, word_n;
    logic             b_n, valid_n, done_n;

    logic             load, shift, sout, begin_frame;
    logic [WIDTH-1:0] src;

    seq1010_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .shift(shift),
        .d    (src),
        .sout (sout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            rep_cnt <= '0;
            rep_lim <= '0;
            word    <= '0;
            b       <= 1'b0;
            b_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_n;
            gap_cnt <= gap_n;
            rep_cnt <= rep_n;
            rep_lim <= rep_lim_n;
            word    <= word_n;
            b       <= b_n;
            b_valid <= valid_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_n       = bit_cnt;
        gap_n       = gap_cnt;
        rep_n       = rep_cnt;
        rep_lim_n   = rep_lim;
        word_n      = word;
        b_n         = 1'b0;
        valid_n     = 1'b0;
        done_n      = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        src         = word;
        begin_frame = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    word_n      = data_in;
                    rep_lim_n   = repeat_n;
                    rep_n       = '0;
                    src         = data_in;
                    begin_frame = 1'b1;
                end
            end
`ifdef SEQ1010_GEN_PREAMBLE_EN
            S_PRE: begin
                valid_n = 1'b1;
                if (bit_cnt == PRE_LAST) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                    b_n     = sout;
                    shift   = 1'b1;
                end else begin
                    bit_n = bit_cnt + 1'b1;
                    b_n   = pre_bit(bit_n[1:0]);
                end
            end
`endif
            S_DATA: begin
                if (bit_cnt != LAST_BIT) begin
                    bit_n   = bit_cnt + 1'b1;
                    b_n     = sout;
                    valid_n = 1'b1;
                    shift   = 1'b1;
                end else if (rep_cnt != rep_lim) begin
                    rep_n = rep_cnt + 4'd1;
                    if (GAP > 0) begin
                        state_n = S_GAP;
                        gap_n   = '0;
                    end else begin
                        begin_frame = 1'b1;
                    end
                end else begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    begin_frame = 1'b1;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // First bit of a frame is registered on the same edge the
        // word is (re)loaded, so there is no bubble before it.
        if (begin_frame) begin
            load    = 1'b1;
            bit_n   = '0;
            valid_n = 1'b1;
`ifdef SEQ1010_GEN_PREAMBLE_EN
            state_n = S_PRE;
            b_n     = pre_bit(2'd0);
`else
            state_n = S_DATA;
            shift   = 1'b1;
            b_n     = src[WIDTH-1];
`endif
        end
    end

    assign ready = (state == S_IDLE);

endmodule

// File: tb/tb_seq1010_gen.sv
// Self-checking bench for seq1010_gen: directed and random transfers against
// a queue-based model of the expected serial stream.
module tb_seq1010_gen;

    localparam int W = 8;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] data_in;
    logic [3:0]   repeat_n;
    logic         ready, b, b_valid, done;

    int checks = 0;
    int errors = 0;

    seq1010_gen #(
        .WIDTH(W),
        .GAP  (G)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .repeat_n(repeat_n),
        .ready   (ready),
        .b       (b),
        .b_valid (b_valid),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] obs();
        return {ready, done, b_valid, b};
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [3:0] got,
                       input logic [3:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d got{rdy,done,vld,b}=%b want=%b",
                   tag, cyc, got, want);
        end
    endtask

    // Expected {ready,done,b_valid,b} per cycle after the accept edge.
    task automatic build(input logic [W-1:0] d, input int r,
                         output logic [3:0] q[$]);
        q = {};
        for (int k = 0; k <= r; k++) begin
`ifdef SEQ1010_GEN_PREAMBLE_EN
            for (int i = 0; i < 4; i++) q.push_back({3'b001, i % 2 == 0});
`endif
            for (int i = W - 1; i >= 0; i--) q.push_back({3'b001, d[i]});
            if (k < r) for (int g = 0; g < G; g++) q.push_back(4'b0000);
        end
        q.push_back(4'b1100);
    endtask

    // Run one transfer; cut>0 asserts reset after that many cycles.
    task automatic send(input string tag, input logic [W-1:0] d,
                        input logic [3:0] r, input bit noise, input int cut);
        logic [3:0] exp_q[$];
        int n;
        build(d, int'(r), exp_q);
        n = (cut > 0) ? cut : exp_q.size();
        @(negedge clk);
        chk({tag, "_idle"}, 0, obs(), 4'b1000);
        start    = 1'b1;
        data_in  = d;
        repeat_n = r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, i + 1, obs(), exp_q[i]);
            start = 1'b0;
            if (noise && i + 1 < n && i + 1 < exp_q.size() - 1) begin
                start    = 1'($urandom_range(0, 1));
                data_in  = W'($urandom);
                repeat_n = 4'($urandom);
            end
        end
        if (cut > 0) begin
            reset = 1'b1;
            @(negedge clk);
            chk({tag, "_rst"}, n + 1, obs(), 4'b1000);
            reset = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_after"}, n + 2, obs(), 4'b1000);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b1;
        data_in  = 8'h5A;
        repeat_n = 4'd1;
        @(negedge clk);
        chk("reset1", 0, obs(), 4'b1000);
        @(negedge clk);
        chk("reset2", 0, obs(), 4'b1000);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("reset_noaccept", 0, obs(), 4'b1000);

        send("a5", 8'hA5, 4'd0, 1'b0, 0);
        send("zero", 8'h00, 4'd0, 1'b0, 0);
        send("ff_r2", 8'hFF, 4'd2, 1'b0, 0);

        // Mid-frame start with a new word must not disturb the frame.
        @(negedge clk);
        start    = 1'b1;
        data_in  = 8'hC3;
        repeat_n = 4'd0;
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        data_in  = 8'h3C;
        repeat_n = 4'd3;
        begin
            logic [3:0] q[$];
            build(8'hC3, 0, q);
            for (int i = 2; i < q.size(); i++) begin
                chk("ignore_start", i + 1, obs(), q[i]);
                start = 1'b0;
                @(negedge clk);
            end
            chk("ignore_single_done", 0, obs(), 4'b1000);
        end

`ifdef SEQ1010_GEN_PREAMBLE_EN
        send("abort", 8'h96, 4'd1, 1'b0, 8);
`else
        send("abort", 8'h96, 4'd1, 1'b0, 4);
`endif
        send("post_abort", 8'h69, 4'd0, 1'b0, 0);

        // Reset and start together: reset wins.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("rst_start", 0, obs(), 4'b1000);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", 0, obs(), 4'b1000);

        send("r15", 8'h81, 4'd15, 1'b0, 0);

        for (int t = 0; t < 8; t++) begin
            send("rand", W'($urandom), 4'($urandom_range(0, 3)), 1'b1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
